// File: rtl/muldiv_seq_if.sv
// Handshake/data bundle between the decode/control path and muldiv_seq.
// The control path drives the master side and muldiv_seq implements the slave side.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;

  modport master (
    output start, func3, op_a, op_b, kill,
    input  busy, done, result, stall
  );

  modport slave (
    input  start, func3, op_a, op_b, kill,
    output busy, done, result, stall
  );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply and restoring divide.
// Defining MULDIV_FAST_MUL_EN gives single-cycle combinational multiplies.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_sgn, b_sgn, div_zero, ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, trial, diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, step_nx, prod;
  logic [XLEN-1:0]   quo, rem, fin;

  always_comb begin
    a_sgn    = bus.op_a[XLEN-1] & (bus.func3 inside {3'd1, 3'd2, 3'd4, 3'd6});
    b_sgn    = bus.op_b[XLEN-1] & (bus.func3 inside {3'd1, 3'd4, 3'd6});
    mag_a    = a_sgn ? -bus.op_a : bus.op_a;
    mag_b    = b_sgn ? -bus.op_b : bus.op_b;
    div_zero = bus.func3[2] & (bus.op_b == '0);
    ovf      = bus.func3[2] & ~bus.func3[0] & (bus.op_a == INT_MIN) & (bus.op_b == '1);
  end

  // Multiply keeps the multiplier in acc low half and shifts right; divide shifts
  // the dividend out of the low half (quotient) into the high half (remainder).
  always_comb begin
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nx  = {sum, acc_q[XLEN-1:1]};
    trial   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff    = trial - {1'b0, b_q};
    div_nx  = diff[XLEN] ? {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step_nx = f3_q[2] ? div_nx : mul_nx;
    prod    = neg_q ? -step_nx : step_nx;
    quo     = neg_q ? -step_nx[XLEN-1:0] : step_nx[XLEN-1:0];
    rem     = neg_q ? -step_nx[2*XLEN-1:XLEN] : step_nx[2*XLEN-1:XLEN];
    case (f3_q)
      3'd0:       fin = prod[XLEN-1:0];
      3'd4, 3'd5: fin = quo;
      3'd6, 3'd7: fin = rem;
      default:    fin = prod[2*XLEN-1:XLEN];
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fp;
  always_comb begin
    fa = {{XLEN{a_sgn}}, bus.op_a};
    fb = {{XLEN{b_sgn}}, bus.op_b};
    fp = fa * fb;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          f3_d  = bus.func3;
          a_d   = mag_a;
          b_d   = mag_b;
          neg_d = (bus.func3 == 3'd6) ? a_sgn
                : (bus.func3 inside {3'd1, 3'd2, 3'd4}) ? (a_sgn ^ b_sgn) : 1'b0;
          acc_d = bus.func3[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
          cnt_d = '1;
          if (div_zero) begin
            result_d = bus.func3[1] ? bus.op_a : '1;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = bus.func3[1] ? '0 : INT_MIN;
            state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!bus.func3[2]) begin
            result_d = (bus.func3 == 3'd0) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
            state_d  = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = fin;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == S_CALC) | (state_q == S_DONE);
  assign bus.done   = (state_q == S_DONE) & ~bus.kill;
  assign bus.result = result_q;
  assign bus.stall  = (bus.start & (state_q == S_IDLE) & ~bus.kill) | (state_q == S_CALC);
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: driver queues expected results, negedge monitor checks them.
module tb_muldiv_seq;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          iss;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   stall_cnt = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [31:0] last_exp = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_seq_if #(.XLEN(32)) bus ();
  muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (rst || bus.kill) stall_cnt = 0;
    else if (bus.stall) stall_cnt++;
    if (bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.name, "_result"}, bus.result, mon_e.res);
        check({mon_e.name, "_latency"}, 32'(cyc - mon_e.iss), 32'(mon_e.lat));
        check({mon_e.name, "_stall_cycles"}, 32'(stall_cnt), 32'(mon_e.lat));
      end
      stall_cnt = 0;
    end
  end

  task automatic wait_empty(input string nm);
    int k = 0;
    while (sbq.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, k);
      sbq.delete();
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat, input string nm);
    exp_t x;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.func3 = f;
    bus.op_a  = a;
    bus.op_b  = b;
    x.res = r; x.lat = lat; x.iss = cyc; x.name = nm;
    sbq.push_back(x);
    last_exp = r;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_empty(nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int iss;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.func3 = '0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst = 1'b0;

    issue(3'd0, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, MUL_LAT, "mul_7_m6");
    issue(3'd0, 32'h12345678, 32'h10,       32'h23456780, MUL_LAT, "mul_wrap");
    issue(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, "mulh_min");
    issue(3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, MUL_LAT, "mulh_m3_5");
    issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "mulhu_max");
    issue(3'd3, 32'h80000000, 32'd4,        32'h00000002, MUL_LAT, "mulhu_2p33");
    issue(3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT, "mulhsu_m1_2");
    issue(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, "div_m7_2");
    issue(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, "rem_m7_2");
    issue(3'd4, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, DIV_LAT, "div_20_m3");
    issue(3'd6, 32'd20,       32'hFFFFFFFD, 32'h00000002, DIV_LAT, "rem_20_m3");
    issue(3'd5, 32'd100,      32'd7,        32'd14,       DIV_LAT, "divu_100_7");
    issue(3'd7, 32'd100,      32'd7,        32'd2,        DIV_LAT, "remu_100_7");
    issue(3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DIV_LAT, "divu_max_1");
    issue(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,       "divu_by0");
    issue(3'd6, 32'd5,        32'd0,        32'd5,        1,       "rem_by0");
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,       "div_ovf");
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,       "rem_ovf");
    issue(3'd7, 32'd9,        32'd4,        32'd1,        DIV_LAT, "remu_9_4");

    // kill at CALC cycle 10
    @(posedge clk); #1;
    bus.start = 1'b1; bus.func3 = 3'd4; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(negedge clk);
    check("kill_done_same_cycle", {31'b0, bus.done}, 32'd0);
    @(posedge clk); #1;
    bus.kill = 1'b0;
    check("kill_busy", {31'b0, bus.busy}, 32'd0);
    check("kill_result_kept", bus.result, last_exp);
    repeat (40) @(posedge clk);
    #1;
    check("kill_result_later", bus.result, last_exp);

    // start and kill together
    @(posedge clk); #1;
    bus.start = 1'b1; bus.kill = 1'b1; bus.func3 = 3'd5;
    @(negedge clk);
    check("startkill_stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.kill = 1'b0;
    check("startkill_busy", {31'b0, bus.busy}, 32'd0);
    repeat (40) @(posedge clk);

    // start pulses in CALC and DONE are ignored
    @(posedge clk); #1;
    bus.start = 1'b1; bus.func3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
    iss = cyc;
    begin
      exp_t x;
      x.res = 32'd14; x.lat = DIV_LAT; x.iss = iss; x.name = "ign_divu";
      sbq.push_back(x);
    end
    last_exp = 32'd14;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.func3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < iss + DIV_LAT) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1; bus.func3 = 3'd5; bus.op_a = 32'd1; bus.op_b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_empty("ign_divu");
    repeat (40) @(posedge clk);
    #1;
    check("ign_busy", {31'b0, bus.busy}, 32'd0);
    check("ign_result", bus.result, 32'd14);

    // reset mid-CALC
    @(posedge clk); #1;
    bus.start = 1'b1; bus.func3 = 3'd4; bus.op_a = 32'd50; bus.op_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    check("midrst_stall", {31'b0, bus.stall}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    issue(3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT, "post_rst_remu");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions (opcode 0110011, funct7 0000001). It sits beside the single-cycle ALU in execute and accepts one operation at a time from the decode/control path. It runs an iterative shift-add multiply or restoring divide, and holds the pipeline with `stall` until the result is ready. It also handles the RISC-V divide-by-zero and signed-overflow corner cases without iterating.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a new operation; sampled only in IDLE.
- `func3` input 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op_a` input XLEN: rs1 value; sampled with `start`.
- `op_b` input XLEN: rs2 value; sampled with `start`.
- `kill` input 1: flush; aborts any operation in flight.
- `busy` output 1: high in CALC and DONE.
- `done` output 1: one-cycle pulse; `result` is valid in that cycle.
- `result` output XLEN: registered result, held until the next accepted `start`.
- `stall` output 1: combinational pipeline hold, equal to (`start` & IDLE & !`kill`) | CALC.

## Operation
- States:
  - IDLE: accepts an operation.
  - CALC: iterates.
  - DONE: presents the result.
- IDLE
  - `start` & !`kill` captures `func3` and the operands. For signed forms it also captures the operand magnitudes and the result sign.
  - Divide by zero (`op_b`==0, func3 4–7) goes to DONE. The result is: DIV/DIVU = 0xFFFFFFFF; REM/REMU = `op_a`.
  - Signed overflow (DIV/REM, `op_a`=0x80000000, `op_b`=0xFFFFFFFF) goes to DONE. The result is: DIV = 0x80000000; REM = 0.
  - Any other request goes to CALC with the 5-bit counter set to 31.
- CALC
  - Each cycle performs one iteration and decrements the counter.
  - Multiply: 64-bit accumulator, shift-add on the magnitudes.
  - Divide: restoring divide on the magnitudes, with 32-bit quotient and remainder registers.
  - On the iteration where the counter is 0:
    - Apply sign correction.
    - Load `result`: MUL takes the low 32 bits; MULH/HSU/HU take the high 32 bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
    - Go to DONE.
  - Sign rules:
    - MULH: signed × signed.
    - MULHSU: signed `op_a` × unsigned `op_b`.
    - Quotient sign = sign(a) XOR sign(b).
    - Remainder sign = sign(a).
- DONE
  - `done`=1 for this cycle only, then return to IDLE.
  - `start` is ignored in DONE and becomes acceptable again in the following IDLE cycle.
- `kill`
  - In any state, the next state is IDLE and `done` is not produced in that cycle or the next.
  - `result` keeps its previous value.
  - `kill` and `start` in the same cycle: `kill` wins and nothing is accepted.
- `start` outside IDLE is ignored. No request queue exists.

## Timing
- Reset values: state IDLE, counter 0, `result` 0, `done` 0, `busy` 0, `stall` 0 (given `start`=0).
- A reset mid-operation aborts immediately; no `done` is produced.
- Iterative operations:
  - `start` accepted at edge N.
  - CALC occupies cycles N+1 to N+32.
  - DONE at N+33, so `done`/`result` are visible in the cycle after edge N+32.
  - `stall` is high from the request cycle through the last CALC cycle (33 cycles) and low in DONE, so the pipeline advances and captures `result`.
- Fast paths (div-by-zero, overflow): `stall` is high for 1 cycle and DONE follows the request directly; latency 1.
- Back-to-back operations: the minimum issue interval is latency + 1 (DONE to IDLE).

## Configuration
- `MULDIV_FAST_MUL_EN`
  - Defined:
    - func3 0–3 compute a full 64-bit combinational product (signed/unsigned per func3) in the request cycle.
    - `result` is loaded and the FSM goes IDLE to DONE, giving latency 1.
    - Divide timing is unchanged.
  - Undefined:
    - Multiplies use the 32-iteration CALC path with latency 33.
    - No 32×32 multiplier is inferred.

## Test plan
- MUL 7 × 0xFFFFFFFA (−6) → `done` at cycle 33 (1 with FAST) and `result` 0xFFFFFFD6. `stall` is high for exactly 33 cycles (1 with FAST).
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 ÷ 2 → 0xFFFFFFFD (−3). REM −7 ÷ 2 → 0xFFFFFFFF (−1). DIVU 100 ÷ 7 → 14. REMU 100 ÷ 7 → 2. Each has `done` at cycle 33.
- DIVU 5 ÷ 0 → 0xFFFFFFFF and REM 5 ÷ 0 → 5, each with `done` 1 cycle after `start`. DIV 0x80000000 ÷ −1 → 0x80000000 and REM → 0, also with latency 1.
- Start DIV, assert `kill` at CALC cycle 10 → IDLE next cycle, no `done` pulse, `result` unchanged. Also: `start`+`kill` in the same cycle → nothing accepted and `stall`=0.
- Assert `rst` mid-CALC → all outputs 0 immediately. `start` pulses during CALC and DONE → ignored; exactly one `done` is produced per accepted operation.
